// File: rtl/cpu_lsu_param.sv
// MEM-stage load/store unit: XLEN 32/64, B/H/W/D accesses over a valid/ready dcache port.
// Results are registered and commit only when the pipeline accepts them.
module cpu_lsu_param #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_pipeline_ready,
    output logic                o_done,
    input  logic                i_mem,
    input  logic                i_store,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [XLEN-1:0]     i_wdata,
    output logic [XLEN-1:0]     o_rd,
    output logic                o_fault,
    output logic [1:0]          o_fault_code,
    output logic                o_c_valid,
    input  logic                i_c_ready,
    output logic                o_c_we,
    output logic [ADDR_W-1:0]   o_c_addr,
    output logic [XLEN-1:0]     o_c_wdata,
    output logic [XLEN/8-1:0]   o_c_wstrb,
    input  logic                i_c_rvalid,
    input  logic [XLEN-1:0]     i_c_rdata
);
    localparam int unsigned StrbW = XLEN / 8;
    localparam int unsigned LaneW = $clog2(StrbW);
    localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [XLEN-1:0]   rd_q, hold_rd_q;
    logic              fault_q, hold_fault_q;
    logic [1:0]        code_q, hold_code_q;

    logic [LaneW-1:0]  lane;
    logic              illegal, misaligned, bad, tmo_hit, commit;
    logic [7:0]        bmask;
    logic [XLEN-1:0]   addr_ext, sh, dmask, ld_data, cur_rd;
    logic              sbit, cur_fault;
    logic [1:0]        cur_code;

    assign lane     = i_addr[LaneW-1:0];
    assign addr_ext = XLEN'(i_addr);
    assign illegal  = (i_size == 2'd3) && (XLEN == 32);
    assign bad      = illegal || misaligned;
    assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

    always_comb begin
        misaligned = 1'b0;
        bmask      = 8'hFF;
        dmask      = '1;
        sbit       = 1'b0;
        sh         = i_c_rdata >> {lane, 3'b000};
        case (i_size)
            2'd0: begin
                bmask = 8'h01;
                dmask = XLEN'(8'hFF);
                sbit  = sh[7];
            end
            2'd1: begin
                misaligned = i_addr[0];
                bmask      = 8'h03;
                dmask      = XLEN'(16'hFFFF);
                sbit       = sh[15];
            end
            2'd2: begin
                misaligned = |i_addr[1:0];
                bmask      = 8'h0F;
                dmask      = XLEN'(32'hFFFF_FFFF);
                sbit       = sh[31];
            end
            default: misaligned = |i_addr[2:0];
        endcase
        ld_data = (sh & dmask) | ((sbit && !i_unsigned) ? ~dmask : '0);
    end

    // Request fields come straight from the (stable) inputs; only valid depends on state.
    assign o_c_valid = ((state_q == StIdle) && i_mem && !bad) || ((state_q == StReq) && !tmo_hit);
    assign o_c_we    = i_store;
    assign o_c_addr  = {i_addr[ADDR_W-1:LaneW], {LaneW{1'b0}}};
    assign o_c_wdata = i_wdata << {lane, 3'b000};
    assign o_c_wstrb = StrbW'(bmask) << lane;

    always_comb begin
        o_done    = 1'b0;
        cur_rd    = addr_ext;
        cur_fault = 1'b0;
        cur_code  = 2'b00;
        unique case (state_q)
            StIdle: begin
                o_done = !i_mem || bad;
                if (i_mem && bad) begin
                    cur_fault = 1'b1;
                    cur_code  = illegal ? 2'b11 : 2'b01;
                end
            end
            StReq: begin
            end
            StWait: begin
                o_done = i_c_rvalid;
                if (!i_store) cur_rd = ld_data;
            end
            StHold: begin
                o_done    = 1'b1;
                cur_rd    = hold_rd_q;
                cur_fault = hold_fault_q;
                cur_code  = hold_code_q;
            end
        endcase
    end

    assign commit = o_done && i_pipeline_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rd_q         <= '0;
            fault_q      <= 1'b0;
            code_q       <= 2'b00;
            hold_rd_q    <= '0;
            hold_fault_q <= 1'b0;
            hold_code_q  <= 2'b00;
        end else begin
            if (commit) begin
                rd_q    <= cur_rd;
                fault_q <= cur_fault;
                code_q  <= cur_code;
            end
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (i_mem && !bad) state_q <= i_c_ready ? StWait : StReq;
                end
                StReq: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (tmo_hit) begin
                        hold_rd_q    <= addr_ext;
                        hold_fault_q <= 1'b1;
                        hold_code_q  <= 2'b10;
                        state_q      <= StHold;
                    end else if (i_c_ready) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A response arriving on the timeout cycle still wins.
                    if (i_c_rvalid) begin
                        hold_rd_q    <= cur_rd;
                        hold_fault_q <= 1'b0;
                        hold_code_q  <= 2'b00;
                        state_q      <= i_pipeline_ready ? StIdle : StHold;
                    end else if (tmo_hit) begin
                        hold_rd_q    <= addr_ext;
                        hold_fault_q <= 1'b1;
                        hold_code_q  <= 2'b10;
                        state_q      <= StHold;
                    end
                end
                StHold: begin
                    if (i_pipeline_ready) state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_rd         = rd_q;
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;

endmodule

// File: doc/cpu_lsu_param.md
Name: cpu_lsu_param

Overview:
- Parametrised load/store unit for the MEM stage of the 5-stage RISC-V pipeline, replacing the fixed 32-bit memory unit.
- Supports XLEN 32 or 64, and byte/half/word/double accesses.
- Talks to the dcache over a valid/ready request channel with byte strobes.
- Detects misaligned and illegal accesses, and bounds cache latency with a timeout fault.
- Outputs are pipeline-registered and advance only when the pipeline is ready.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, max cycles waiting on the cache before a fault; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_pipeline_ready  in  1  downstream accepts MEM results this cycle
- o_done  out  1  MEM stage finished current instruction (combinational)
- i_mem  in  1  instruction is a load/store
- i_store  in  1  1 = store, 0 = load
- i_size  in  2  0 = B, 1 = H, 2 = W, 3 = D (D legal only when XLEN = 64)
- i_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- i_addr  in  ADDR_W  effective address from ALU; passed through when !i_mem
- i_wdata  in  XLEN  store data (rs2)
- o_rd  out  XLEN  registered result to WB
- o_fault  out  1  registered fault flag
- o_fault_code  out  2  01 misaligned, 10 timeout, 11 illegal size, 00 none
- o_c_valid  out  1  cache request valid
- i_c_ready  in  1  cache accepts request
- o_c_we  out  1  write enable
- o_c_addr  out  ADDR_W  XLEN/8-aligned address
- o_c_wdata  out  XLEN  lane-shifted store data
- o_c_wstrb  out  XLEN/8  byte-enable strobes
- i_c_rvalid  in  1  response (load data or store ack)
- i_c_rdata  in  XLEN  load data word

Behaviour:
- Reset: i_reset is synchronous, active-high, on i_clk. State IDLE; o_rd, o_fault, o_fault_code, timeout counter all 0; o_c_valid 0.
- Reset mid-transaction abandons the access; the dcache shares the same reset.
- Output commit: o_rd, o_fault and o_fault_code load only on cycles with o_done && i_pipeline_ready; otherwise they hold.
- Input stability: inputs are held stable by upstream while o_done = 0.
- Lane selection: lane = i_addr[log2(XLEN/8)-1:0], nbytes = 1 << i_size.
- Misaligned: (i_addr mod nbytes) != 0. Illegal: i_size = 3 with XLEN = 32.
- Store formatting: o_c_wdata = i_wdata << (8*lane); o_c_wstrb = ((1 << nbytes) - 1) << lane; o_c_we = i_store.
- Load formatting: shift i_c_rdata right by 8*lane, keep nbytes, sign-extend to XLEN unless i_unsigned. Word loads with XLEN = 64 also sign-extend unless i_unsigned.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE, !i_mem:
  - o_done = 1; commit value is o_rd = i_addr (zero-extended to XLEN), fault 0.
- IDLE, i_mem with illegal or misaligned access:
  - o_done = 1; no cache request; commit fault 1 with code 11 (illegal takes priority) or 01; o_rd = i_addr.
- IDLE, i_mem and legal:
  - Assert o_c_valid.
  - If i_c_ready, go to WAIT; else go to REQ. o_done = 0.
- REQ:
  - Hold o_c_valid and all request fields stable until i_c_ready, then go to WAIT.
- WAIT:
  - o_done = i_c_rvalid.
  - On i_c_rvalid with i_pipeline_ready: commit the formatted load (store: o_rd = i_addr), go to IDLE.
  - On i_c_rvalid without i_pipeline_ready: latch the result internally, go to HOLD.
  - i_c_rvalid counts only in WAIT; responses seen in other states are ignored.
- HOLD:
  - o_done = 1; commit the latched result when i_pipeline_ready, then go to IDLE.
- Timeout counter:
  - Clears in IDLE; increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT (when TIMEOUT != 0): drop o_c_valid, set fault code 10, go to HOLD. o_rd = i_addr.
- Latency: with an always-ready, 1-cycle cache, o_done rises in the cycle after issue, so 2 cycles per MEM op. Non-MEM ops complete in 0 added cycles.
- Back-to-back: after committing from WAIT or HOLD, IDLE can issue the next request in the following cycle.

Test Plan:
- XLEN = 32, LW at 0x100, cache returns 0xDEADBEEF one cycle after acceptance -> o_c_addr = 0x100, wstrb 0xF, o_done on cycle 1, o_rd = 0xDEADBEEF, fault 0.
- LB at 0x103, rdata 0x80123456 -> o_rd = 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x102, i_wdata = 0x1234BEEF -> o_c_wstrb = 4'b1100, o_c_wdata[31:16] = 0xBEEF, o_c_we = 1; rvalid ack -> o_rd = 0x102.
- LW at 0x1002 -> o_done = 1 same cycle, o_c_valid never asserted, o_fault = 1, code 01. With XLEN = 32 and i_size = 3 -> code 11.
- i_c_ready low for 5 cycles then high, rvalid 3 cycles later, i_pipeline_ready low 2 extra cycles -> request fields stable throughout, HOLD entered, o_rd updates exactly once. TIMEOUT = 8 with no ready -> fault code 10 after 8 cycles, o_c_valid dropped.
- XLEN = 64, LW at 0x104, rdata 0x80000000_00000000 -> o_rd = 0xFFFFFFFF_80000000; LD at 0x108 -> full word, wstrb 0xFF; i_reset during WAIT -> state IDLE, outputs 0.
